// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader: handshake bytes, FSM
// encodings and the little-endian byte-lane merge helper.
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h99;
  localparam logic [7:0] ACK_BYTE  = 8'hAA;

  typedef enum logic [2:0] {
    SEND_SYNC    = 3'd0,
    WAIT_SYNC_TX = 3'd1,
    RECV_SIZE    = 3'd2,
    RECV_DATA    = 3'd3,
    FLUSH        = 3'd4,
    SEND_ACK     = 3'd5,
    WAIT_ACK_TX  = 3'd6,
    DONE         = 3'd7
  } loader_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_PULSE = 2'd1,
    TX_LAG   = 2'd2,
    TX_WAIT  = 2'd3
  } tx_phase_e;

  // Places a byte into lane 'lane' of a 32-bit little-endian word.
  function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data);
    logic [31:0] merged;
    merged = word;
    merged[{lane, 3'b000} +: 8] = data;
    return merged;
  endfunction

endpackage

// File: rtl/loader_tx_seq.sv
// Single-byte UART_TX sequencer: issues one tx_start when the transmitter is
// free, skips the busy-lag cycle, then reports completion with a done pulse.
module loader_tx_seq
  import loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [7:0] data,
  input  logic       tx_busy,
  output logic       accept,
  output logic       done,
  output logic       tx_start,
  output logic [7:0] tx_sdata
);

  tx_phase_e  phase_r, phase_s;
  logic       tx_start_r, tx_start_s;
  logic [7:0] tx_sdata_r, tx_sdata_s;
  logic       done_r, done_s;

  assign accept = (phase_r == TX_IDLE) && req && !tx_busy;

  // Phase register
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_r <= TX_IDLE;
    end else begin
      phase_r <= phase_s;
    end
  end

  // Next phase; TX_LAG is the cycle after tx_start where busy is not yet valid
  always_comb begin
    phase_s = phase_r;
    case (phase_r)
      TX_IDLE: begin
        if (accept) phase_s = TX_PULSE;
        else        phase_s = TX_IDLE;
      end
      TX_PULSE: phase_s = TX_LAG;
      TX_LAG:   phase_s = TX_WAIT;
      TX_WAIT: begin
        if (!tx_busy) phase_s = TX_IDLE;
        else          phase_s = TX_WAIT;
      end
      default:  phase_s = TX_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    tx_start_s = accept;
    done_s     = (phase_r == TX_WAIT) && !tx_busy;
    if (accept) tx_sdata_s = data;
    else        tx_sdata_s = tx_sdata_r;
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_start_r <= 1'b0;
      tx_sdata_r <= 8'h00;
      done_r     <= 1'b0;
    end else begin
      tx_start_r <= tx_start_s;
      tx_sdata_r <= tx_sdata_s;
      done_r     <= done_s;
    end
  end

  assign tx_start = tx_start_r;
  assign tx_sdata = tx_sdata_r;
  assign done     = done_r;

endmodule

// File: rtl/program_loader.sv
// UART boot loader: sync handshake, 32-bit little-endian size, byte stream
// packed into instruction-memory words, ack handshake, then CPU release.
module program_loader
  import loader_pkg::*;
#(
  parameter int IMEM_ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_rdata,
  input  logic                   rx_rdata_ready,
  input  logic                   rx_ferr,
  output logic [7:0]             tx_sdata,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   load_done,
  output logic                   overflow,
  output logic                   ferr_seen
);

  loader_state_e state_r, state_s;

  logic [31:0]            count_r;
  logic [1:0]             lane_r;
  logic [31:0]            word_r;
  logic [31:0]            word_idx_r;
  logic                   imem_we_r;
  logic [IMEM_ADDR_W-1:0] imem_addr_r;
  logic [31:0]            imem_wdata_r;
  logic                   load_done_r;
  logic                   overflow_r;
  logic                   ferr_seen_r;

  logic        send_req_s;
  logic [7:0]  send_byte_s;
  logic        take_size_s;
  logic        take_data_s;
  logic        tx_accept_s;
  logic        tx_done_s;
  logic [31:0] size_full_s;
  logic [31:0] merged_s;
  logic        word_end_s;
  logic        in_range_s;

  loader_tx_seq u_tx_seq (
    .clk      (clk),
    .reset    (reset),
    .req      (send_req_s),
    .data     (send_byte_s),
    .tx_busy  (tx_busy),
    .accept   (tx_accept_s),
    .done     (tx_done_s),
    .tx_start (tx_start),
    .tx_sdata (tx_sdata)
  );

  assign size_full_s = {rx_rdata, count_r[23:0]};
  assign merged_s    = merge_byte(word_r, lane_r, rx_rdata);
  assign word_end_s  = take_data_s && ((lane_r == 2'd3) || (count_r == 32'd1));
  // Word index is wider than the address so out-of-range words are detectable
  assign in_range_s  = ((word_idx_r >> IMEM_ADDR_W) == 32'd0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= SEND_SYNC;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      SEND_SYNC: begin
        if (tx_accept_s) state_s = WAIT_SYNC_TX;
        else             state_s = SEND_SYNC;
      end
      WAIT_SYNC_TX: begin
        if (tx_done_s) state_s = RECV_SIZE;
        else           state_s = WAIT_SYNC_TX;
      end
      RECV_SIZE: begin
        if (take_size_s && (lane_r == 2'd3)) begin
          if (size_full_s != 32'd0) state_s = RECV_DATA;
          else                      state_s = SEND_ACK;
        end else begin
          state_s = RECV_SIZE;
        end
      end
      RECV_DATA: begin
        if (take_data_s && (count_r == 32'd1)) begin
          if (lane_r == 2'd3) state_s = SEND_ACK;
          else                state_s = FLUSH;
        end else begin
          state_s = RECV_DATA;
        end
      end
      FLUSH: state_s = SEND_ACK;
      SEND_ACK: begin
        if (tx_accept_s) state_s = WAIT_ACK_TX;
        else             state_s = SEND_ACK;
      end
      WAIT_ACK_TX: begin
        if (tx_done_s) state_s = DONE;
        else           state_s = WAIT_ACK_TX;
      end
      DONE:    state_s = DONE;
      default: state_s = SEND_SYNC;
    endcase
  end

  // Per-state control outputs; strobes outside the RECV states are dropped
  always_comb begin
    send_req_s  = 1'b0;
    send_byte_s = 8'h00;
    take_size_s = 1'b0;
    take_data_s = 1'b0;
    case (state_r)
      SEND_SYNC: begin
        send_req_s  = 1'b1;
        send_byte_s = SYNC_BYTE;
      end
      SEND_ACK: begin
        send_req_s  = 1'b1;
        send_byte_s = ACK_BYTE;
      end
      RECV_SIZE: take_size_s = rx_rdata_ready;
      RECV_DATA: take_data_s = rx_rdata_ready;
      default: begin
        send_req_s  = 1'b0;
        send_byte_s = 8'h00;
      end
    endcase
  end

  // Datapath: size capture, word packing and the registered imem write port.
  // Partial words are written on the completing strobe, so imem_we is high
  // during FLUSH with the unfilled lanes still zero from the last clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r      <= 32'd0;
      lane_r       <= 2'd0;
      word_r       <= 32'd0;
      word_idx_r   <= 32'd0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= '0;
      imem_wdata_r <= 32'd0;
      load_done_r  <= 1'b0;
      overflow_r   <= 1'b0;
      ferr_seen_r  <= 1'b0;
    end else begin
      if (take_size_s) begin
        count_r[{lane_r, 3'b000} +: 8] <= rx_rdata;
        lane_r                         <= lane_r + 2'd1;
      end else if (take_data_s) begin
        count_r <= count_r - 32'd1;
        lane_r  <= lane_r + 2'd1;
        word_r  <= word_end_s ? 32'd0 : merged_s;
      end
      if (word_end_s) begin
        word_idx_r   <= word_idx_r + 32'd1;
        imem_addr_r  <= word_idx_r[IMEM_ADDR_W-1:0];
        imem_wdata_r <= merged_s;
      end
      imem_we_r <= word_end_s && in_range_s;
      if (word_end_s && !in_range_s) overflow_r <= 1'b1;
      if ((take_size_s || take_data_s) && rx_ferr) ferr_seen_r <= 1'b1;
      load_done_r <= (state_s == DONE);
    end
  end

  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign load_done  = load_done_r;
  assign overflow   = overflow_r;
  assign ferr_seen  = ferr_seen_r;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a default-width loader and a 2-bit-address
// loader share one UART stimulus; a small UART_TX model drives tx_busy.
module tb_program_loader;
  import loader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  rx_rdata;
  logic        rx_rdata_ready;
  logic        rx_ferr;
  logic        tx_busy;
  logic [7:0]  tx_sdata;
  logic        tx_start;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        load_done, overflow, ferr_seen;

  logic [7:0]  b_tx_sdata;
  logic        b_tx_start;
  logic        b_imem_we;
  logic [1:0]  b_imem_addr;
  logic [31:0] b_imem_wdata;
  logic        b_load_done, b_overflow, b_ferr_seen;

  program_loader #(.IMEM_ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .rx_rdata(rx_rdata), .rx_rdata_ready(rx_rdata_ready),
    .rx_ferr(rx_ferr), .tx_sdata(tx_sdata), .tx_start(tx_start), .tx_busy(tx_busy),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .load_done(load_done), .overflow(overflow), .ferr_seen(ferr_seen)
  );

  program_loader #(.IMEM_ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .rx_rdata(rx_rdata), .rx_rdata_ready(rx_rdata_ready),
    .rx_ferr(rx_ferr), .tx_sdata(b_tx_sdata), .tx_start(b_tx_start), .tx_busy(tx_busy),
    .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
    .load_done(b_load_done), .overflow(b_overflow), .ferr_seen(b_ferr_seen)
  );

  int checks = 0;
  int failures = 0;
  int viol = 0;
  int busy_cnt = 0;
  logic [7:0]  txq[$];
  logic [41:0] wq[$];
  logic [33:0] wq2[$];

  // UART_TX model (busy rises the cycle after tx_start) plus tx/imem monitors
  always @(negedge clk) begin
    if (imem_we)   wq.push_back({imem_addr, imem_wdata});
    if (b_imem_we) wq2.push_back({b_imem_addr, b_imem_wdata});
    if (reset) begin
      busy_cnt <= 0;
      tx_busy  <= 1'b0;
    end else begin
      if (tx_start && tx_busy) viol <= viol + 1;
      if (b_tx_start !== tx_start) viol <= viol + 1;
      tx_busy <= (busy_cnt != 0);
      if (tx_start) begin
        txq.push_back(tx_sdata);
        busy_cnt <= 4;
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_tx(input int limit, output logic [7:0] b, output logic got);
    int n;
    n = 0;
    got = 1'b0;
    b = 8'h00;
    while (txq.size() == 0 && n < limit) begin
      tick();
      n++;
    end
    if (txq.size() != 0) begin
      b = txq.pop_front();
      got = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fe);
    rx_rdata = b;
    rx_ferr = fe;
    rx_rdata_ready = 1'b1;
    tick();
    rx_rdata_ready = 1'b0;
    rx_ferr = 1'b0;
    tick();
  endtask

  task automatic send_size(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], 1'b0);
  endtask

  task automatic start_load();
    logic [7:0] b;
    logic got;
    reset = 1'b1;
    tick();
    tick();
    txq.delete();
    wq.delete();
    wq2.delete();
    reset = 1'b0;
    wait_tx(4, b, got);
    checks++;
    if (!got || b !== SYNC_BYTE)
      $display("FAIL sync_byte: got=%0b byte=%h expected=%h", got, b, SYNC_BYTE);
    if (!got || b !== SYNC_BYTE) failures++;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_rdata = 8'h55;
    rx_rdata_ready = 1'b1;
    tick();
    tick();
    rx_rdata_ready = 1'b0;
    checks++;
    if ({tx_start, tx_sdata, imem_we, imem_addr, imem_wdata, load_done, overflow, ferr_seen} !== 55'd0) begin
      $display("FAIL reset_outputs: start=%b sdata=%h we=%b addr=%h wdata=%h done=%b ovf=%b ferr=%b expected all zero",
               tx_start, tx_sdata, imem_we, imem_addr, imem_wdata, load_done, overflow, ferr_seen);
      failures++;
    end
    txq.delete();
    wq.delete();
    wq2.delete();
    reset = 1'b0;
    tick();
    checks++;
    if (tx_start !== 1'b1 || tx_sdata !== SYNC_BYTE) begin
      $display("FAIL reset_sync_start: tx_start=%b tx_sdata=%h expected 1/%h", tx_start, tx_sdata, SYNC_BYTE);
      failures++;
    end
    repeat (12) tick();
    checks++;
    if (wq.size() != 0 || load_done !== 1'b0) begin
      $display("FAIL reset_idle: writes=%0d load_done=%b expected 0/0", wq.size(), load_done);
      failures++;
    end
  endtask

  task automatic test_word_load();
    logic [7:0] b;
    logic got;
    logic [7:0]  data[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    logic [41:0] exp_w[2] = '{{10'd0, 32'h00000013}, {10'd1, 32'h00100093}};
    start_load();
    send_size(32'd8);
    for (int i = 0; i < 8; i++) send_byte(data[i], 1'b0);
    wait_tx(20, b, got);
    checks++;
    if (!got || b !== ACK_BYTE) begin
      $display("FAIL word_ack: got=%0b byte=%h expected=%h", got, b, ACK_BYTE);
      failures++;
    end
    checks++;
    if (wq.size() != 2) begin
      $display("FAIL word_count: writes=%0d expected=2", wq.size());
      failures++;
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wq[i] !== exp_w[i]) begin
          $display("FAIL word_write%0d: got=%h expected=%h", i, wq[i], exp_w[i]);
          failures++;
        end
      end
    end
    repeat (12) tick();
    checks++;
    if (load_done !== 1'b1) begin
      $display("FAIL word_load_done: load_done=%b expected=1", load_done);
      failures++;
    end
  endtask

  task automatic test_done_ignores_rx();
    for (int i = 0; i < 5; i++) send_byte(8'hF0 + 8'(i), 1'b0);
    repeat (10) tick();
    checks++;
    if (wq.size() != 2 || txq.size() != 0 || load_done !== 1'b1) begin
      $display("FAIL done_ignore: writes=%0d tx=%0d load_done=%b expected 2/0/1", wq.size(), txq.size(), load_done);
      failures++;
    end
  endtask

  task automatic test_flush();
    logic [7:0] b;
    logic got;
    logic [41:0] exp_w[2] = '{{10'd0, 32'h04030201}, {10'd1, 32'h00000605}};
    start_load();
    send_size(32'd6);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
    checks++;
    if (load_done !== 1'b0) begin
      $display("FAIL flush_early_done: load_done=%b expected=0", load_done);
      failures++;
    end
    wait_tx(20, b, got);
    checks++;
    if (!got || b !== ACK_BYTE) begin
      $display("FAIL flush_ack: got=%0b byte=%h expected=%h", got, b, ACK_BYTE);
      failures++;
    end
    checks++;
    if (wq.size() != 2) begin
      $display("FAIL flush_count: writes=%0d expected=2", wq.size());
      failures++;
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wq[i] !== exp_w[i]) begin
          $display("FAIL flush_write%0d: got=%h expected=%h", i, wq[i], exp_w[i]);
          failures++;
        end
      end
    end
  endtask

  task automatic test_zero_size();
    logic [7:0] b;
    logic got;
    start_load();
    send_size(32'd0);
    wait_tx(2, b, got);
    checks++;
    if (!got || b !== ACK_BYTE) begin
      $display("FAIL zero_ack: got=%0b byte=%h expected=%h", got, b, ACK_BYTE);
      failures++;
    end
    repeat (12) tick();
    checks++;
    if (wq.size() != 0 || load_done !== 1'b1) begin
      $display("FAIL zero_result: writes=%0d load_done=%b expected 0/1", wq.size(), load_done);
      failures++;
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    logic got;
    logic [33:0] exp_w;
    start_load();
    send_size(32'd20);
    for (int i = 1; i <= 20; i++) send_byte(8'(i), 1'b0);
    wait_tx(20, b, got);
    checks++;
    if (!got || b !== ACK_BYTE) begin
      $display("FAIL ovf_ack: got=%0b byte=%h expected=%h", got, b, ACK_BYTE);
      failures++;
    end
    checks++;
    if (wq2.size() != 4 || b_overflow !== 1'b1) begin
      $display("FAIL ovf_small: writes=%0d overflow=%b expected 4/1", wq2.size(), b_overflow);
      failures++;
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_w = {2'(i), 8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
        checks++;
        if (wq2[i] !== exp_w) begin
          $display("FAIL ovf_write%0d: got=%h expected=%h", i, wq2[i], exp_w);
          failures++;
        end
      end
    end
    checks++;
    if (wq.size() != 5 || overflow !== 1'b0) begin
      $display("FAIL ovf_wide: writes=%0d overflow=%b expected 5/0", wq.size(), overflow);
      failures++;
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] b;
    logic got;
    start_load();
    send_size(32'd8);
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hC3, 1'b0);
    checks++;
    if (ferr_seen !== 1'b1) begin
      $display("FAIL abort_ferr: ferr_seen=%b expected=1", ferr_seen);
      failures++;
    end
    txq.delete();
    wq.delete();
    // reset coincides with the strobe that would complete word 0
    reset = 1'b1;
    rx_rdata = 8'hD4;
    rx_rdata_ready = 1'b1;
    tick();
    rx_rdata_ready = 1'b0;
    reset = 1'b0;
    wait_tx(4, b, got);
    checks++;
    if (!got || b !== SYNC_BYTE) begin
      $display("FAIL abort_resync: got=%0b byte=%h expected=%h", got, b, SYNC_BYTE);
      failures++;
    end
    repeat (12) tick();
    checks++;
    if (wq.size() != 0 || ferr_seen !== 1'b0) begin
      $display("FAIL abort_no_write: writes=%0d ferr_seen=%b expected 0/0", wq.size(), ferr_seen);
      failures++;
    end
  endtask

  task automatic test_ferr_data();
    logic [7:0] b;
    logic got;
    start_load();
    send_size(32'd4);
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hD4, 1'b0);
    wait_tx(20, b, got);
    checks++;
    if (!got || b !== ACK_BYTE || ferr_seen !== 1'b1) begin
      $display("FAIL ferr_ack: got=%0b byte=%h ferr_seen=%b expected %h/1", got, b, ferr_seen, ACK_BYTE);
      failures++;
    end
    checks++;
    if (wq.size() != 1 || wq[0] !== {10'd0, 32'hD4C3B2A1}) begin
      $display("FAIL ferr_data: writes=%0d first=%h expected 1/%h", wq.size(),
               (wq.size() != 0) ? wq[0] : 42'd0, {10'd0, 32'hD4C3B2A1});
      failures++;
    end
  endtask

  task automatic test_tx_protocol();
    checks++;
    if (viol != 0) begin
      $display("FAIL tx_protocol: violations=%0d expected=0", viol);
      failures++;
    end
  endtask

  initial begin
    reset = 1'b1;
    rx_rdata = 8'h00;
    rx_rdata_ready = 1'b0;
    rx_ferr = 1'b0;
    tx_busy = 1'b0;
    test_reset();
    test_word_load();
    test_done_ignores_rx();
    test_flush();
    test_zero_size();
    test_overflow();
    test_reset_abort();
    test_ferr_data();
    test_tx_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter IMEM_ADDR_W, default 10, giving the instruction-memory word-address width (1024 words).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have ports rx_rdata (input, 8), rx_rdata_ready (input, 1, one-cycle strobe per received byte) and rx_ferr (input, 1), driven by UART_RX.
REQ-005 The block SHALL have ports tx_sdata (output, 8), tx_start (output, 1, one-cycle pulse) and tx_busy (input, 1), connected to UART_TX.
REQ-006 The block SHALL have ports imem_we (output, 1), imem_addr (output, IMEM_ADDR_W) and imem_wdata (output, 32), the instruction-memory write port.
REQ-007 The block SHALL have status ports load_done (output, 1, CPU release), overflow (output, 1, sticky) and ferr_seen (output, 1, sticky).

Function
REQ-008 States SHALL be SEND_SYNC, WAIT_SYNC_TX, RECV_SIZE, RECV_DATA, FLUSH, SEND_ACK, WAIT_ACK_TX and DONE; reset enters SEND_SYNC.
REQ-009 SEND_SYNC: on the first cycle with tx_busy low, drive tx_sdata=0x99, pulse tx_start for one cycle and go to WAIT_SYNC_TX.
REQ-010 WAIT_*_TX: ignore tx_busy in the cycle after tx_start (UART_TX busy lags by one cycle), then wait until tx_busy is low. WAIT_SYNC_TX then goes to RECV_SIZE; WAIT_ACK_TX goes to DONE.
REQ-011 RECV_SIZE: accept 4 strobed bytes, little-endian, into a 32-bit byte count. After the 4th byte: go to RECV_DATA if count is nonzero, else to SEND_ACK.
REQ-012 RECV_DATA: pack each byte into a 32-bit word, little-endian (byte i of a word goes to bits 8i+7:8i), and decrement the remaining count.
REQ-013 When a word completes, assert imem_we for exactly one cycle, in the cycle after the completing strobe, with imem_addr = word index (starting at 0) and imem_wdata = the word.
REQ-014 Word index SHALL increment after each write and SHALL NOT wrap.
REQ-015 If remaining count reaches 0 mid-word, go to FLUSH. FLUSH writes the partial word with its unfilled upper bytes zero, for one cycle, then goes to SEND_ACK.
REQ-016 If remaining count reaches 0 on a word boundary, go directly to SEND_ACK.
REQ-017 Words with index >= 2^IMEM_ADDR_W SHALL be received and counted but not written (no imem_we), and SHALL set overflow.
REQ-018 A strobe with rx_ferr high SHALL set ferr_seen; the byte is still consumed, so the count stays aligned.
REQ-019 rx_rdata_ready SHALL be ignored in SEND_*, WAIT_*, FLUSH and DONE.
REQ-020 SEND_ACK behaves as SEND_SYNC but with tx_sdata=0xAA.
REQ-021 DONE is terminal until reset; load_done is high only in DONE; tx_start is never pulsed in DONE.
REQ-022 At most one tx_start per byte; tx_start is never asserted while tx_busy is high (excluding the lag cycle).
REQ-023 The count SHALL be 32-bit unsigned, with no limit check other than REQ-017.

Reset
REQ-024 On reset: tx_start=0, tx_sdata=0, imem_we=0, imem_addr=0, imem_wdata=0, load_done=0, overflow=0, ferr_seen=0; byte count, byte lane and word index cleared; state=SEND_SYNC.
REQ-025 Reset asserted mid-load SHALL abort the load within one cycle, with no further imem_we. After release the handshake restarts with 0x99.
REQ-026 Reset has priority over a simultaneous rx_rdata_ready.

Structure
REQ-027 A shared package loader_pkg SHALL hold the state enum and constants SYNC_BYTE=8'h99 and ACK_BYTE=8'hAA, reused by the testbench server.
REQ-028 One sub-module, loader_tx_seq, SHALL be used: it sends one byte, handles the busy-lag rule (REQ-010) and returns a done pulse. All else is flat.

Verification
REQ-029 Reset release, tx_busy low -> tx_start with 0x99 within 1 cycle; no imem_we until size bytes arrive.
REQ-030 Size 08 00 00 00, data 13 00 00 00 93 00 10 00 -> writes (0,0x00000013), (1,0x00100093); then 0xAA; load_done high.
REQ-031 Size 06 00 00 00, data 01 02 03 04 05 06 -> writes (0,0x04030201), (1,0x00000605) via FLUSH; then 0xAA.
REQ-032 Size 00 00 00 00 -> no imem_we; 0xAA sent right after the 4th size byte; load_done high.
REQ-033 IMEM_ADDR_W=2, size 20 -> 4 writes (addr 0..3), overflow=1, 0xAA still sent after the 20th byte.
REQ-034 Reset pulsed after the 3rd data byte -> no further writes; 0x99 resent; ferr strobe on the 1st data byte -> ferr_seen=1 and data intact.
